// File: rtl/wav_pkg.sv
// Shared types and defaults for the oscilloscope ping-pong capture controller.
// No logic; consumed by wav_capture_ctrl and wav_trig_detect.
package wav_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLDOFF,
    ST_WAIT_TRIG,
    ST_CAPTURE,
    ST_DONE
  } wav_state_t;

  localparam int WAV_ADDR_W    = 10;
  localparam int WAV_DATA_W    = 8;
  localparam int WAV_HOLDOFF_W = 32;

  // Display starts on the bank opposite the first write bank.
  localparam logic RD_BANK_RST = 1'b1;

endpackage

// File: rtl/wav_trig_detect.sv
// Rising-crossing trigger comparator with an auto-trigger timeout counter.
// Combinational hit/force from registered prev sample and timeout count; no backpressure.
module wav_trig_detect
  import wav_pkg::*;
#(
  parameter int DATA_W    = WAV_DATA_W,
  parameter int HOLDOFF_W = WAV_HOLDOFF_W
) (
  input  logic                 pclk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  input  logic [DATA_W-1:0]    s_data,
  input  logic                 in_wait,
  input  logic [DATA_W-1:0]    cfg_trig_level,
  input  logic [HOLDOFF_W-1:0] cfg_trig_timeout,
  output logic                 trig_hit,
  output logic                 trig_force
);

  logic [DATA_W-1:0]    prev;
  logic [HOLDOFF_W-1:0] to_cnt;

  // prev tracks every sample so the crossing compares against the true predecessor.
  always_ff @(posedge pclk) begin
    if (!rst_n)
      prev <= '0;
    else if (s_valid)
      prev <= s_data;
  end

  // Counter holds once the timeout is reached so it cannot wrap while waiting for a sample.
  always_ff @(posedge pclk) begin
    if (!rst_n || !in_wait)
      to_cnt <= '0;
    else if (!trig_force)
      to_cnt <= to_cnt + 1'b1;
  end

  assign trig_hit   = s_valid && (prev < cfg_trig_level) && (s_data >= cfg_trig_level);
  assign trig_force = (cfg_trig_timeout != '0) && (to_cnt >= cfg_trig_timeout);

endmodule

// File: rtl/wav_capture_ctrl.sv
// Ping-pong waveform capture sequencer; bank swap only on vsync after a full frame.
// Writes registered 1 cycle after s_valid; no backpressure. WAV_TRIG_EN adds trigger/timeout.
module wav_capture_ctrl
  import wav_pkg::*;
#(
  parameter int ADDR_W    = WAV_ADDR_W,
  parameter int DATA_W    = WAV_DATA_W,
  parameter int HOLDOFF_W = WAV_HOLDOFF_W
) (
  input  logic                 pclk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  input  logic [DATA_W-1:0]    s_data,
  input  logic                 i_vs,
  input  logic                 cfg_single,
  input  logic                 cfg_start,
  input  logic [HOLDOFF_W-1:0] cfg_holdoff,
  input  logic [DATA_W-1:0]    cfg_trig_level,
  input  logic [HOLDOFF_W-1:0] cfg_trig_timeout,
  output logic                 wr_en,
  output logic [ADDR_W:0]      wr_addr,
  output logic [DATA_W-1:0]    wr_data,
  output logic                 rd_bank,
  output logic                 frame_ready,
  output logic                 auto_trig,
  output logic                 busy
);

  wav_state_t           state;
  logic                 wr_bank;
  logic [ADDR_W-1:0]    cnt;
  logic [HOLDOFF_W-1:0] hold_lat;
  logic [HOLDOFF_W-1:0] hold_cnt;
  logic                 vs_d;
  logic                 vs_rise;

  assign vs_rise = i_vs && !vs_d;

`ifdef WAV_TRIG_EN
  localparam wav_state_t HOLDOFF_NEXT = ST_WAIT_TRIG;

  logic trig_hit;
  logic trig_force;

  wav_trig_detect #(
    .DATA_W    (DATA_W),
    .HOLDOFF_W (HOLDOFF_W)
  ) u_trig_detect (
    .pclk             (pclk),
    .rst_n            (rst_n),
    .s_valid          (s_valid),
    .s_data           (s_data),
    .in_wait          (state == ST_WAIT_TRIG),
    .cfg_trig_level   (cfg_trig_level),
    .cfg_trig_timeout (cfg_trig_timeout),
    .trig_hit         (trig_hit),
    .trig_force       (trig_force)
  );
`else
  // Free-run: holdoff leads straight into capture; trigger config has no effect.
  localparam wav_state_t HOLDOFF_NEXT = ST_CAPTURE;

  logic unused_cfg;
  assign unused_cfg = ^{cfg_trig_level, cfg_trig_timeout};
`endif

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      wr_bank     <= 1'b0;
      cnt         <= '0;
      hold_lat    <= '0;
      hold_cnt    <= '0;
      vs_d        <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      rd_bank     <= RD_BANK_RST;
      frame_ready <= 1'b0;
      auto_trig   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      wr_en       <= 1'b0;
      frame_ready <= 1'b0;
      vs_d        <= i_vs;

      case (state)
        ST_IDLE: begin
          if (!cfg_single || cfg_start) begin
            state    <= ST_HOLDOFF;
            hold_lat <= cfg_holdoff;
            hold_cnt <= '0;
            busy     <= 1'b1;
          end
        end

        ST_HOLDOFF: begin
          if (hold_cnt == hold_lat)
            state <= HOLDOFF_NEXT;
          else
            hold_cnt <= hold_cnt + 1'b1;
        end

`ifdef WAV_TRIG_EN
        ST_WAIT_TRIG: begin
          // A real crossing takes priority over the timeout when both fire together.
          if (s_valid && (trig_hit || trig_force)) begin
            wr_en     <= 1'b1;
            wr_addr   <= {wr_bank, {ADDR_W{1'b0}}};
            wr_data   <= s_data;
            cnt       <= {{(ADDR_W-1){1'b0}}, 1'b1};
            auto_trig <= !trig_hit;
            state     <= ST_CAPTURE;
          end
        end
`endif

        ST_CAPTURE: begin
          if (s_valid) begin
            wr_en   <= 1'b1;
            wr_addr <= {wr_bank, cnt};
            wr_data <= s_data;
            cnt     <= cnt + 1'b1;
            if (cnt == {ADDR_W{1'b1}})
              state <= ST_DONE;
          end
        end

        ST_DONE: begin
          // Swapping only here keeps the display from ever reading a half-written bank.
          if (vs_rise) begin
            rd_bank     <= wr_bank;
            wr_bank     <= ~wr_bank;
            frame_ready <= 1'b1;
            if (cfg_single) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              state    <= ST_HOLDOFF;
              hold_lat <= cfg_holdoff;
              hold_cnt <= '0;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wav_capture_ctrl.sv
// Directed bench for wav_capture_ctrl; expectations cover both WAV_TRIG_EN builds.
`timescale 1ns/1ps
module tb_wav_capture_ctrl;

  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 8;
  localparam int HOLDOFF_W = 32;

  logic                 pclk = 1'b0;
  logic                 rst_n;
  logic                 s_valid;
  logic [DATA_W-1:0]    s_data;
  logic                 i_vs;
  logic                 cfg_single;
  logic                 cfg_start;
  logic [HOLDOFF_W-1:0] cfg_holdoff;
  logic [DATA_W-1:0]    cfg_trig_level;
  logic [HOLDOFF_W-1:0] cfg_trig_timeout;
  logic                 wr_en;
  logic [ADDR_W:0]      wr_addr;
  logic [DATA_W-1:0]    wr_data;
  logic                 rd_bank;
  logic                 frame_ready;
  logic                 auto_trig;
  logic                 busy;

  wav_capture_ctrl #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .HOLDOFF_W (HOLDOFF_W)
  ) dut (
    .pclk             (pclk),
    .rst_n            (rst_n),
    .s_valid          (s_valid),
    .s_data           (s_data),
    .i_vs             (i_vs),
    .cfg_single       (cfg_single),
    .cfg_start        (cfg_start),
    .cfg_holdoff      (cfg_holdoff),
    .cfg_trig_level   (cfg_trig_level),
    .cfg_trig_timeout (cfg_trig_timeout),
    .wr_en            (wr_en),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .rd_bank          (rd_bank),
    .frame_ready      (frame_ready),
    .auto_trig        (auto_trig),
    .busy             (busy)
  );

  always #5 pclk = ~pclk;

  int              n_chk = 0;
  int              n_err = 0;
  int              cyc;
  int              n_wr;
  int              n_fr;
  int              seq_err;
  int              first_cyc;
  logic [ADDR_W:0] first_addr;
  logic [7:0]      first_data;
  logic [7:0]      ramp;
  bit              const_mode;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic clr_mon();
    n_wr      = 0;
    n_fr      = 0;
    seq_err   = 0;
    first_cyc = -1;
    first_addr = '0;
    first_data = '0;
  endtask

  // One pclk: sample outputs 1ns after the edge, then drive the next sample.
  task automatic tick();
    logic [7:0] exp_d;
    @(posedge pclk);
    #1;
    cyc++;
    if (wr_en === 1'b1) begin
      if (n_wr == 0) begin
        first_addr = wr_addr;
        first_data = wr_data;
        first_cyc  = cyc;
      end else begin
        if (int'(wr_addr) != int'(first_addr) + n_wr) seq_err++;
        exp_d = const_mode ? 8'd10 : first_data + 8'(n_wr);
        if (wr_data !== exp_d) seq_err++;
      end
      n_wr++;
    end
    if (frame_ready === 1'b1) n_fr++;
    s_valid = 1'b1;
    s_data  = const_mode ? 8'd10 : ramp;
    ramp    = ramp + 8'd1;
  endtask

  task automatic hold_reset();
    rst_n = 1'b0;
    repeat (3) tick();
  endtask

  // After release, the edge numbered k samples ramp value k-1.
  task automatic release_reset();
    ramp    = 8'd0;
    s_data  = const_mode ? 8'd10 : 8'd0;
    ramp    = 8'd1;
    rst_n   = 1'b1;
    cyc     = 0;
    clr_mon();
  endtask

  task automatic wait_wr(input int n, input int lim);
    int k;
    k = 0;
    while (n_wr < n && k < lim) begin
      tick();
      k++;
    end
  endtask

  task automatic vsync();
    i_vs = 1'b1;
    repeat (3) tick();
    i_vs = 1'b0;
    tick();
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_wr_en"},   32'(wr_en), 32'd0);
    check({pfx, "_wr_addr"}, 32'(wr_addr), 32'd0);
    check({pfx, "_wr_data"}, 32'(wr_data), 32'd0);
    check({pfx, "_rd_bank"}, 32'(rd_bank), 32'd1);
    check({pfx, "_fr"},      32'(frame_ready), 32'd0);
    check({pfx, "_auto"},    32'(auto_trig), 32'd0);
    check({pfx, "_busy"},    32'(busy), 32'd0);
  endtask

  initial begin
    rst_n            = 1'b0;
    s_valid          = 1'b0;
    s_data           = '0;
    i_vs             = 1'b0;
    cfg_single       = 1'b0;
    cfg_start        = 1'b0;
    cfg_holdoff      = 32'd4;
    cfg_trig_level   = 8'd128;
    cfg_trig_timeout = 32'd0;
    const_mode       = 1'b0;
    ramp             = 8'd0;
    cyc              = 0;
    clr_mon();

    // Reset state
    hold_reset();
    check_reset_vals("rst");

    // Continuous capture with a vsync edge arriving mid-capture
    release_reset();
    wait_wr(300, 2000);
    check("cont_mid_cnt", 32'(n_wr), 32'd300);
    vsync();
    check("cont_mid_fr", 32'(n_fr), 32'd0);
    check("cont_mid_rdb", 32'(rd_bank), 32'd1);
    wait_wr(1024, 3000);
    check("cont_n_wr", 32'(n_wr), 32'd1024);
    check("cont_first_addr", 32'(first_addr), 32'd0);
`ifdef WAV_TRIG_EN
    check("cont_first_data", 32'(first_data), 32'd128);
`else
    check("cont_first_data", 32'(first_data), 32'd6);
    check("cont_first_cyc", 32'(first_cyc), 32'd7);
`endif
    check("cont_seq", 32'(seq_err), 32'd0);
    repeat (20) tick();
    check("done_no_wr", 32'(n_wr), 32'd1024);
    check("done_busy", 32'(busy), 32'd1);
    check("done_no_fr", 32'(n_fr), 32'd0);
    check("done_rdb", 32'(rd_bank), 32'd1);
    vsync();
    check("swap_fr", 32'(n_fr), 32'd1);
    check("swap_rdb", 32'(rd_bank), 32'd0);
    check("swap_auto", 32'(auto_trig), 32'd0);

    // Second frame goes to bank 1, then reset at cnt=500
    clr_mon();
    wait_wr(500, 2000);
    check("f2_cnt", 32'(n_wr), 32'd500);
    check("f2_first_addr", 32'(first_addr), 32'd1024);
    rst_n = 1'b0;
    repeat (2) tick();
    check_reset_vals("midrst");
    release_reset();
    wait_wr(1, 2000);
    check("postrst_n_wr", 32'(n_wr), 32'd1);
    check("postrst_addr", 32'(first_addr), 32'd0);

    // Constant data with a 100-cycle timeout
    hold_reset();
    const_mode       = 1'b1;
    cfg_trig_timeout = 32'd100;
    release_reset();
    wait_wr(1024, 3000);
    check("to_n_wr", 32'(n_wr), 32'd1024);
    check("to_first_data", 32'(first_data), 32'd10);
    check("to_seq", 32'(seq_err), 32'd0);
`ifdef WAV_TRIG_EN
    check("to_first_cyc", 32'(first_cyc), 32'd107);
`else
    check("to_first_cyc", 32'(first_cyc), 32'd7);
`endif
    vsync();
    check("to_rdb", 32'(rd_bank), 32'd0);
`ifdef WAV_TRIG_EN
    check("to_auto", 32'(auto_trig), 32'd1);
`else
    check("to_auto", 32'(auto_trig), 32'd0);
`endif

    // Single-shot
    hold_reset();
    const_mode       = 1'b0;
    cfg_trig_timeout = 32'd0;
    cfg_single       = 1'b1;
    release_reset();
    repeat (20) tick();
    check("ss_idle_busy", 32'(busy), 32'd0);
    check("ss_idle_wr", 32'(n_wr), 32'd0);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    wait_wr(200, 2000);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    wait_wr(1024, 3000);
    check("ss_n_wr", 32'(n_wr), 32'd1024);
    check("ss_first_addr", 32'(first_addr), 32'd0);
    vsync();
    check("ss_fr", 32'(n_fr), 32'd1);
    check("ss_rdb", 32'(rd_bank), 32'd0);
    check("ss_busy_after", 32'(busy), 32'd0);
    repeat (1500) tick();
    check("ss_no_rearm", 32'(n_wr), 32'd1024);
    check("ss_still_idle", 32'(busy), 32'd0);
    clr_mon();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    wait_wr(1, 2000);
    check("ss2_n_wr", 32'(n_wr), 32'd1);
    check("ss2_first_addr", 32'(first_addr), 32'd1024);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
